// File: rtl/flowing_led_ctrl_if.sv
// rtl/flowing_led_ctrl_if.sv - configuration handshake bundle for flowing_led_ctrl
//
// Carries one configuration word from a host to the LED sequencer.
//   cfg_valid   host -> block  host presents a configuration word
//   cfg_ready   block -> host  word accepted on an edge where both are high
//   cfg_mode    host -> block  0 rotate-right, 1 rotate-left, 2 bounce, 3 hold
//   cfg_div     host -> block  step period minus 1, in enabled cycles
//   cfg_pattern host -> block  LED pattern loaded after the accept
// Modports: master (host side), slave (sequencer side).
interface flowing_led_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 24
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [1:0]            cfg_mode;
    logic [DIV_WIDTH-1:0]  cfg_div;
    logic [DATA_WIDTH-1:0] cfg_pattern;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_div,
        output cfg_pattern,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_div,
        input  cfg_pattern,
        output cfg_ready
    );
endinterface

// File: rtl/flowing_led_ctrl.sv
// rtl/flowing_led_ctrl.sv - flowing-LED sequencer with prescaler, modes and config handshake
//
// Owns the LED pattern register and advances it on prescaler step events.
// Build option: define FLOWING_LED_CTRL_BOUNCE_EN to make mode 2 a bounce
// (ping-pong) chase; without it mode 2 behaves exactly like hold.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous, active-high reset
//   en    in   run enable; 0 pauses stepping and freezes the prescaler
//   cfg   slave modport of flowing_led_ctrl_if (valid/ready config word)
//   led   out  registered LED drive
//   step  out  registered one-cycle pulse, high the cycle after led advanced
module flowing_led_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    DIV_WIDTH     = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_PATTERN = 8'hEF,
    parameter logic [DIV_WIDTH-1:0]  DIV_RESET     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    flowing_led_ctrl_if.slave     cfg,
    output logic [DATA_WIDTH-1:0] led,
    output logic                  step
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RIGHT  = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
`ifdef FLOWING_LED_CTRL_BOUNCE_EN
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    // pos counts 0 .. DATA_WIDTH-2 within one sweep direction
    localparam int         POS_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH - 1) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_WIDTH - 2);
`endif

    state_t                state;
    state_t                state_nxt;
    logic                  ready_c;
    logic                  accept;
    logic                  tick;

    logic [1:0]            mode_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic [DIV_WIDTH-1:0]  presc;
    logic [DATA_WIDTH-1:0] led_shift;

`ifdef FLOWING_LED_CTRL_BOUNCE_EN
    logic                  dir_q;   // 0 = right, 1 = left
    logic [POS_W-1:0]      pos_q;
`endif

    function automatic logic [DATA_WIDTH-1:0] rot_right(input logic [DATA_WIDTH-1:0] v);
        return {v[0], v[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rot_left(input logic [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        // ready depends on state alone so the host never sees a loop
        // through cfg_valid
        ready_c   = (state != S_APPLY);
        accept    = cfg.cfg_valid && ready_c;

        case (state)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    state_nxt = S_APPLY;
                end else if (en) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_APPLY: begin
                state_nxt = en ? S_RUN : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign cfg.cfg_ready = ready_c;

    // An accept always wins over a coincident terminal count: the old
    // pattern must not advance on the edge the new word is captured.
    assign tick = (state == S_RUN) && !accept && (presc == div_q);

    // ------------------------------------------------------------------
    // Next pattern for a step event, selected by mode
    // ------------------------------------------------------------------
    always_comb begin
        led_shift = led;
        case (mode_q)
            MODE_RIGHT:  led_shift = rot_right(led);
            MODE_LEFT:   led_shift = rot_left(led);
`ifdef FLOWING_LED_CTRL_BOUNCE_EN
            MODE_BOUNCE: led_shift = dir_q ? rot_left(led) : rot_right(led);
`endif
            default:     led_shift = led;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: config capture, prescaler, LED register, step pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= RESET_PATTERN;
            step      <= 1'b0;
            mode_q    <= MODE_RIGHT;
            div_q     <= DIV_RESET;
            pattern_q <= '0;
            presc     <= '0;
        end else begin
            step <= tick;

            if (accept) begin
                mode_q    <= cfg.cfg_mode;
                div_q     <= cfg.cfg_div;
                pattern_q <= cfg.cfg_pattern;
            end

            if (state == S_APPLY) begin
                led   <= pattern_q;
                presc <= '0;
            end else if ((state == S_RUN) && !accept) begin
                if (presc == div_q) begin
                    presc <= '0;
                    led   <= led_shift;
                end else begin
                    presc <= presc + DIV_WIDTH'(1);
                end
            end
        end
    end

`ifdef FLOWING_LED_CTRL_BOUNCE_EN
    // Sweep tracking: DATA_WIDTH-1 steps per direction, starting right.
    // The direction flips after the step that completes a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
            pos_q <= '0;
        end else if (state == S_APPLY) begin
            dir_q <= 1'b0;
            pos_q <= '0;
        end else if (tick && (mode_q == MODE_BOUNCE)) begin
            if (pos_q == POS_LAST) begin
                pos_q <= '0;
                dir_q <= ~dir_q;
            end else begin
                pos_q <= pos_q + POS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_flowing_led_ctrl.sv
// tb/tb_flowing_led_ctrl.sv - self-checking bench for flowing_led_ctrl
`timescale 1ns/1ps
module tb_flowing_led_ctrl;
    localparam int DW = 8;
    localparam int VW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] led;
    logic          step;

    flowing_led_ctrl_if #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) cfg_if ();

    flowing_led_ctrl #(
        .DATA_WIDTH   (DW),
        .DIV_WIDTH    (VW),
        .RESET_PATTERN(8'hEF),
        .DIV_RESET    (24'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cfg (cfg_if),
        .led (led),
        .step(step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          valid;
        logic [1:0]    mode;
        logic [VW-1:0] div;
        logic [DW-1:0] pat;
        logic [DW-1:0] exp_led;
        logic          exp_step;
        logic          exp_ready;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic e, input logic v, input logic [1:0] m,
                                input logic [VW-1:0] d, input logic [DW-1:0] p,
                                input logic [DW-1:0] el, input logic es, input logic er);
        vec_t r;
        r.en = e; r.valid = v; r.mode = m; r.div = d; r.pat = p;
        r.exp_led = el; r.exp_step = es; r.exp_ready = er;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] left_seq [4];
        logic [DW-1:0] prev;
        logic [DW-1:0] bounce_seq [15];
        logic [DW-1:0] exp_led;
        int            steps;

        left_seq   = '{8'hDF, 8'hBF, 8'h7F, 8'hFE};
        bounce_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                       8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h80};

        // free-running right rotation from reset, one step per cycle
        add(1, 0, 0, 0, 0, 8'hEF, 0, 1);
        add(1, 0, 0, 0, 0, 8'hF7, 1, 1);
        add(1, 0, 0, 0, 0, 8'hFB, 1, 1);
        add(1, 0, 0, 0, 0, 8'hFD, 1, 1);
        add(1, 0, 0, 0, 0, 8'hFE, 1, 1);
        add(1, 0, 0, 0, 0, 8'h7F, 1, 1);
        add(1, 0, 0, 0, 0, 8'hBF, 1, 1);
        // accept mode=1 div=3 pattern=EF; coincident terminal count is dropped
        add(1, 1, 1, 3, 8'hEF, 8'hBF, 0, 0);
        add(1, 0, 0, 0, 0,     8'hEF, 0, 1);
        prev = 8'hEF;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, prev, 0, 1);
            add(1, 0, 0, 0, 0, left_seq[k], 1, 1);
            prev = left_seq[k];
        end

        rst = 1'b1;
        en  = 1'b0;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_mode    = 2'd0;
        cfg_if.cfg_div     = '0;
        cfg_if.cfg_pattern = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_led",   32'(led), 32'hEF);
        chk("reset_step",  32'(step), 32'd0);
        chk("reset_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            en                 = vecs[i].en;
            cfg_if.cfg_valid   = vecs[i].valid;
            cfg_if.cfg_mode    = vecs[i].mode;
            cfg_if.cfg_div     = vecs[i].div;
            cfg_if.cfg_pattern = vecs[i].pat;
            tick();
            chk($sformatf("vec%0d_led", i),   32'(led), 32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_step", i),  32'(step), 32'(vecs[i].exp_step));
            chk($sformatf("vec%0d_ready", i), 32'(cfg_if.cfg_ready), 32'(vecs[i].exp_ready));
        end

        // bounce (or hold when the bounce build option is off), div=0
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = 2'd2;
        cfg_if.cfg_div = 24'd0;  cfg_if.cfg_pattern = 8'h01;
        tick();
        chk("bounce_accept_ready", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        tick();
        chk("bounce_apply_led",  32'(led), 32'h01);
        chk("bounce_apply_step", 32'(step), 32'd0);
        for (int k = 0; k < 15; k++) begin
            tick();
`ifdef FLOWING_LED_CTRL_BOUNCE_EN
            chk($sformatf("bounce%0d_led", k), 32'(led), 32'(bounce_seq[k]));
`else
            chk($sformatf("bounce%0d_led", k), 32'(led), 32'h01);
`endif
            chk($sformatf("bounce%0d_step", k), 32'(step), 32'd1);
        end

        // div=4 with en low for 10 cycles mid-period
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = 2'd0;
        cfg_if.cfg_div = 24'd4;  cfg_if.cfg_pattern = 8'hEF;
        tick();
        chk("pause_accept_ready", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        tick();
        chk("pause_apply_led", 32'(led), 32'hEF);
        steps = 0;
        for (int e = 1; e <= 20; e++) begin
            en = (e >= 3 && e <= 12) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("pause%0d_step", e), 32'(step), ((e == 15) || (e == 20)) ? 32'd1 : 32'd0);
            chk($sformatf("pause%0d_led", e), 32'(led),
                (e < 15) ? 32'hEF : ((e < 20) ? 32'hF7 : 32'hFB));
            if (step) steps++;
        end
        // RUN cycles counted over the window: 3 before the pause lands, 7 after = 10
        chk("pause_total_steps", 32'(steps), 32'd2);

        // cfg_valid held high: accept every other cycle, no steps
        en = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = 2'd0; cfg_if.cfg_div = 24'd0;
        exp_led = 8'hFB;
        for (int j = 1; j <= 8; j++) begin
            cfg_if.cfg_pattern = 8'(j * 17);
            tick();
            if ((j % 2) == 0) exp_led = 8'((j - 1) * 17);
            chk($sformatf("stream%0d_led", j),   32'(led), 32'(exp_led));
            chk($sformatf("stream%0d_step", j),  32'(step), 32'd0);
            chk($sformatf("stream%0d_ready", j), 32'(cfg_if.cfg_ready), ((j % 2) == 0) ? 32'd1 : 32'd0);
        end
        cfg_if.cfg_valid = 1'b0;
        tick();
        chk("after_stream_led",  32'(led), 32'hBB);
        chk("after_stream_step", 32'(step), 32'd1);

        // asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        chk("rst_run_led",   32'(led), 32'hEF);
        chk("rst_run_step",  32'(step), 32'd0);
        chk("rst_run_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick(); chk("post_rst0_led", 32'(led), 32'hEF); chk("post_rst0_step", 32'(step), 32'd0);
        tick(); chk("post_rst1_led", 32'(led), 32'hF7); chk("post_rst1_step", 32'(step), 32'd1);
        tick(); chk("post_rst2_led", 32'(led), 32'hFB); chk("post_rst2_step", 32'(step), 32'd1);

        // asynchronous reset during APPLY drops the pending word
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = 2'd1;
        cfg_if.cfg_div = 24'd2;  cfg_if.cfg_pattern = 8'h5A;
        tick();
        chk("apply_rst_accept_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("apply_rst_accept_led",   32'(led), 32'hFB);
        cfg_if.cfg_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_apply_led",   32'(led), 32'hEF);
        chk("rst_apply_step",  32'(step), 32'd0);
        chk("rst_apply_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick(); chk("post_rst3_led", 32'(led), 32'hEF); chk("post_rst3_step", 32'(step), 32'd0);
        tick(); chk("post_rst4_led", 32'(led), 32'hF7); chk("post_rst4_step", 32'(step), 32'd1);
        tick(); chk("post_rst5_led", 32'(led), 32'hFB); chk("post_rst5_step", 32'(step), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
